// File: rtl/amp_peak_detect.sv
// Peak detector for the QFT amplitude vector: latches N complex amplitudes, scans one per cycle
// for the largest |re|^2+|im|^2 and reports index/magnitude. Define PEAK_SUM_EN to also build sum_mag.
module amp_peak_detect #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W*2-1:0]       S_amp [N],
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [SEL_W-1:0]          peak_idx,
  output logic [DATA_W*2-1:0]       peak_mag,
  output logic [DATA_W*2+SEL_W-1:0] sum_mag,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned MagW = 2 * DATA_W;
  localparam int unsigned AccW = MagW + SEL_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N - 1);

  logic [1:0]        state_q, state_d;
  logic [MagW-1:0]   bank_q [N];
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [MagW-1:0]   best_mag_q, best_mag_d;
  logic [SEL_W-1:0]  best_idx_q, best_idx_d;
  logic [SEL_W-1:0]  peak_idx_q;
  logic [MagW-1:0]   peak_mag_q;
  logic              load_bank;
  logic              load_out;

  // Magnitude of the entry currently under scan
  logic signed [DATA_W-1:0] re, im;
  logic signed [MagW-1:0]   re_ext, im_ext;
  logic signed [MagW-1:0]   re_sq, im_sq;
  logic [MagW-1:0]          mag;
  logic                     take_new;
  logic [MagW-1:0]          cand_mag;
  logic [SEL_W-1:0]         cand_idx;
  logic                     last_entry;

  always_comb begin
    re     = bank_q[idx_q][MagW-1:DATA_W];
    im     = bank_q[idx_q][DATA_W-1:0];
    re_ext = {{DATA_W{re[DATA_W-1]}}, re};
    im_ext = {{DATA_W{im[DATA_W-1]}}, im};
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    // Each square is at most 2^(2*DATA_W-2), so the sum never wraps
    mag    = $unsigned(re_sq) + $unsigned(im_sq);
  end

  // Strict compare keeps ties on the lowest index; entry 0 always seeds the running best
  assign take_new   = (idx_q == '0) || (mag > best_mag_q);
  assign cand_mag   = take_new ? mag : best_mag_q;
  assign cand_idx   = take_new ? idx_q : best_idx_q;
  assign last_entry = (idx_q == LastIdx);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_mag_d = best_mag_q;
    best_idx_d = best_idx_q;
    load_bank  = 1'b0;
    load_out   = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          load_bank  = 1'b1;
          idx_d      = '0;
          best_mag_d = '0;
          best_idx_d = '0;
          state_d    = StScan;
        end
      end
      StScan: begin
        best_mag_d = cand_mag;
        best_idx_d = cand_idx;
        if (last_entry) begin
          load_out = 1'b1;
          state_d  = StDone;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      best_mag_q <= '0;
      best_idx_q <= '0;
      peak_idx_q <= '0;
      peak_mag_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_mag_q <= best_mag_d;
      best_idx_q <= best_idx_d;
      if (load_bank) begin
        for (int i = 0; i < int'(N); i++) begin
          bank_q[i] <= S_amp[i];
        end
      end
      // Results latch on the final scan edge and hold through IDLE until the next scan ends
      if (load_out) begin
        peak_idx_q <= cand_idx;
        peak_mag_q <= cand_mag;
      end
    end
  end

`ifdef PEAK_SUM_EN
  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] sum_mag_q;

  always_comb begin
    acc_d = acc_q;
    if (state_q == StIdle && in_valid) begin
      acc_d = '0;
    end else if (state_q == StScan) begin
      acc_d = acc_q + {{SEL_W{1'b0}}, mag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      sum_mag_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (load_out) begin
        sum_mag_q <= acc_d;
      end
    end
  end

  assign sum_mag = sum_mag_q;
`else
  assign sum_mag = {AccW{1'b0}};
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign peak_idx  = peak_idx_q;
  assign peak_mag  = peak_mag_q;

endmodule

// File: tb/tb_amp_peak_detect.sv
// Directed bench for amp_peak_detect (N=4, DATA_W=8); expected sums depend on PEAK_SUM_EN.
module tb_amp_peak_detect;

  localparam int unsigned N = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 2;

`ifdef PEAK_SUM_EN
  localparam bit SumEn = 1'b1;
`else
  localparam bit SumEn = 1'b0;
`endif

  localparam logic [63:0] VecBasic   = {16'h0000, 16'hFE02, 16'h0003, 16'h0100};
  localparam logic [63:0] VecTie     = {16'h0000, 16'h0101, 16'h00FD, 16'h0300};
  localparam logic [63:0] VecZero    = 64'h0;
  localparam logic [63:0] VecExtreme = {16'h7F00, 16'h8080, 16'h7F00, 16'h7F00};

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   s_amp [N];
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] peak_idx;
  logic [15:0]   peak_mag;
  logic [17:0]   sum_mag;
  logic          out_valid;
  logic          out_ready;

  int n_cmp = 0;
  int n_err = 0;

  amp_peak_detect #(
    .N     (N),
    .DATA_W(DW),
    .SEL_W (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .S_amp    (s_amp),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .peak_idx (peak_idx),
    .peak_mag (peak_mag),
    .sum_mag  (sum_mag),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic drive_vec(input logic [63:0] vec);
    for (int i = 0; i < int'(N); i++) s_amp[i] = vec[i*16 +: 16];
  endtask

  // Offers a vector, returns cycles from acceptance edge to out_valid (-1 on timeout)
  task automatic send_vec(input logic [63:0] vec, output int lat);
    @(negedge clk);
    drive_vec(vec);
    in_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_vec(VecZero);
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (peak_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", peak_idx); end
    n_cmp++; if (peak_mag !== 16'd0) begin n_err++; $display("FAIL reset_mag: got %0d want 0", peak_mag); end
    n_cmp++; if (sum_mag !== 18'd0) begin n_err++; $display("FAIL reset_sum: got %0d want 0", sum_mag); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    send_vec(VecBasic, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (peak_idx !== 2'd1) begin n_err++; $display("FAIL basic_idx: got %0d want 1", peak_idx); end
    n_cmp++; if (peak_mag !== 16'd9) begin n_err++; $display("FAIL basic_mag: got %0d want 9", peak_mag); end
    n_cmp++; if (sum_mag !== (SumEn ? 18'd18 : 18'd0)) begin
      n_err++; $display("FAIL basic_sum: got %0d want %0d", sum_mag, SumEn ? 18 : 0);
    end
    accept_result();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_tie_and_zero();
    int lat;
    send_vec(VecTie, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL tie_latency: got %0d want 4", lat); end
    n_cmp++; if (peak_idx !== 2'd0) begin n_err++; $display("FAIL tie_idx: got %0d want 0", peak_idx); end
    n_cmp++; if (peak_mag !== 16'd9) begin n_err++; $display("FAIL tie_mag: got %0d want 9", peak_mag); end
    n_cmp++; if (sum_mag !== (SumEn ? 18'd20 : 18'd0)) begin
      n_err++; $display("FAIL tie_sum: got %0d want %0d", sum_mag, SumEn ? 20 : 0);
    end
    accept_result();
    send_vec(VecZero, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL zero_latency: got %0d want 4", lat); end
    n_cmp++; if (peak_idx !== 2'd0) begin n_err++; $display("FAIL zero_idx: got %0d want 0", peak_idx); end
    n_cmp++; if (peak_mag !== 16'd0) begin n_err++; $display("FAIL zero_mag: got %0d want 0", peak_mag); end
    n_cmp++; if (sum_mag !== 18'd0) begin n_err++; $display("FAIL zero_sum: got %0d want 0", sum_mag); end
    accept_result();
  endtask

  task automatic test_extreme();
    int lat;
    send_vec(VecExtreme, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL extreme_latency: got %0d want 4", lat); end
    n_cmp++; if (peak_idx !== 2'd2) begin n_err++; $display("FAIL extreme_idx: got %0d want 2", peak_idx); end
    n_cmp++; if (peak_mag !== 16'h8000) begin n_err++; $display("FAIL extreme_mag: got %0d want 32768", peak_mag); end
    n_cmp++; if (sum_mag !== (SumEn ? 18'd81155 : 18'd0)) begin
      n_err++; $display("FAIL extreme_sum: got %0d want %0d", sum_mag, SumEn ? 81155 : 0);
    end
    accept_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    // After the handshake edge, in_ready is high in the very next cycle
    send_vec(VecBasic, lat);
    accept_result();
    send_vec(VecExtreme, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    n_cmp++; if (peak_idx !== 2'd2) begin n_err++; $display("FAIL b2b_idx: got %0d want 2", peak_idx); end
    n_cmp++; if (peak_mag !== 16'h8000) begin n_err++; $display("FAIL b2b_mag: got %0d want 32768", peak_mag); end
    accept_result();
  endtask

  task automatic test_backpressure();
    int lat;
    send_vec(VecBasic, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL bp_latency: got %0d want 4", lat); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) begin
        drive_vec(VecExtreme);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_%0d: got %b want 1", k, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_ready); end
      n_cmp++; if (peak_idx !== 2'd1) begin n_err++; $display("FAIL bp_idx_%0d: got %0d want 1", k, peak_idx); end
      n_cmp++; if (peak_mag !== 16'd9) begin n_err++; $display("FAIL bp_mag_%0d: got %0d want 9", k, peak_mag); end
    end
    in_valid = 1'b0;
    accept_result();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    // The pulsed vector must not have started a scan
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_ignored_valid: got %b want 0", out_valid); end
    n_cmp++; if (peak_idx !== 2'd1) begin n_err++; $display("FAIL bp_retain_idx: got %0d want 1", peak_idx); end
    n_cmp++; if (peak_mag !== 16'd9) begin n_err++; $display("FAIL bp_retain_mag: got %0d want 9", peak_mag); end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    @(negedge clk);
    drive_vec(VecExtreme);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (peak_idx !== 2'd0) begin n_err++; $display("FAIL rst_scan_idx: got %0d want 0", peak_idx); end
    n_cmp++; if (peak_mag !== 16'd0) begin n_err++; $display("FAIL rst_scan_mag: got %0d want 0", peak_mag); end
    n_cmp++; if (sum_mag !== 18'd0) begin n_err++; $display("FAIL rst_scan_sum: got %0d want 0", sum_mag); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_scan_valid: got %b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_scan_ready: got %b want 1", in_ready); end
    send_vec(VecBasic, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL rst_fresh_latency: got %0d want 4", lat); end
    n_cmp++; if (peak_idx !== 2'd1) begin n_err++; $display("FAIL rst_fresh_idx: got %0d want 1", peak_idx); end
    n_cmp++; if (peak_mag !== 16'd9) begin n_err++; $display("FAIL rst_fresh_mag: got %0d want 9", peak_mag); end
    n_cmp++; if (sum_mag !== (SumEn ? 18'd18 : 18'd0)) begin
      n_err++; $display("FAIL rst_fresh_sum: got %0d want %0d", sum_mag, SumEn ? 18 : 0);
    end
    accept_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_and_zero();
    test_extreme();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/amp_peak_detect.md
# amp_peak_detect

Downstream consumer of the QFT stage's `S_amp` amplitude vector. It captures all N complex amplitudes in one cycle, then scans them sequentially, one per cycle, computing |re|²+|im|² for each. It reports the index and magnitude of the largest entry through a valid/ready output handshake. This is the measurement/readout stage that turns the QFT output state into a most-probable basis index.

## Interface
- `N`, 2: number of amplitudes (basis states); power of two, ≥2.
- `DATA_W`, 32: width of each real/imag component, signed two's complement.
- `SEL_W`, `$clog2(N)`: index width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `S_amp`  in  [DATA_W*2-1:0] x N  amplitude vector; `[DATA_W*2-1:DATA_W]` = re, `[DATA_W-1:0]` = im.
- `in_valid`  in  1  `S_amp` is valid this cycle.
- `in_ready`  out  1  block can accept a vector; high only in IDLE.
- `peak_idx`  out  SEL_W  index of the largest magnitude.
- `peak_mag`  out  DATA_W*2  unsigned |re|²+|im|² of the winning entry.
- `sum_mag`  out  DATA_W*2+SEL_W  unsigned sum of all N magnitudes (see Configuration).
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `in_ready`=1. When `in_valid`=1, latch all N entries into an internal bank and clear `idx`=0, `best_mag`=0, `best_idx`=0, `acc`=0. Then go to SCAN.
- SCAN: each cycle, compute `mag` = re²+im² of `bank[idx]`, with sign-extended multiplies.
  - If `mag` > `best_mag` (strict), or `idx`==0, load `best_mag`/`best_idx`. Ties therefore go to the lowest index.
  - Add `mag` to `acc`.
  - When `idx`==N-1, go to DONE. Otherwise increment `idx`.
- DONE: `out_valid`=1, and `peak_idx`/`peak_mag`/`sum_mag` are driven from the registers.
  - On `out_valid`&&`out_ready`, return to IDLE.
  - Outputs stay stable while `out_ready`=0.
- `in_valid` outside IDLE is ignored; the bank is not overwritten.
- Width rules:
  - re², im² ≤ 2^(2·DATA_W-2), so the sum ≤ 2^(2·DATA_W-1) and fits DATA_W*2 bits unsigned with no overflow.
  - `acc` is DATA_W*2+SEL_W bits and cannot overflow.
- Output registers retain the last result in IDLE. `out_valid` is 0 outside DONE.
- Reset (any state, including mid-SCAN): state=IDLE, `in_ready`=1, `out_valid`=0, `peak_idx`=0, `peak_mag`=0, `sum_mag`=0, `idx`=0, bank cleared. The scan in progress is discarded.

## Timing
- Acceptance: the edge where `in_valid`&&`in_ready`; call it edge 0. `in_ready` drops in the following cycle.
- Entry i is evaluated at edge i+1. DONE is entered at edge N, so `out_valid` rises N cycles after acceptance.
- Handshake edge in DONE → IDLE on that edge; `in_ready`=1 in the next cycle. Minimum period between accepted vectors is N+2 cycles.
- There is no combinational path from `in_valid` or `out_ready` to any output.
- The multiplier is single-cycle combinational. Any added pipelining shifts the latency and requires a spec update.

## Configuration
- `PEAK_SUM_EN` defined: `acc` and its adder are built, and `sum_mag` reports the total magnitude. This is used by software to normalise `peak_mag` into a probability.
- `PEAK_SUM_EN` undefined: the accumulator is not instantiated and `sum_mag` is tied to 0. Peak behaviour and timing are identical.

## Test plan
- N=4, DATA_W=8; input (1,0),(0,3),(-2,2),(0,0). Expect `out_valid` 4 cycles after acceptance with `peak_idx`=1, `peak_mag`=9. With the macro, `sum_mag`=18; without it, `sum_mag`=0.
- Tie: (3,0),(0,-3),(1,1),(0,0) → `peak_idx`=0, `peak_mag`=9. All-zero vector → `peak_idx`=0, `peak_mag`=0.
- Extreme: entry 2 = (-128,-128), others (127,0). Expect `peak_idx`=2, `peak_mag`=32768 (0x8000). With the macro, `sum_mag`=32768+3·16129=81155.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE and pulse `in_valid` with a different vector. Expect outputs unchanged, `in_ready`=0, and the second vector ignored. Raising `out_ready` gives IDLE and `in_ready`=1 on the next cycle.
- Reset mid-SCAN: assert `rst` at the second SCAN cycle. Outputs must be 0 immediately (asynchronous), `in_ready`=1 after release, and a fresh vector then yields the correct result.
